// File: rtl/tx_layer_pkg.sv
// Shared definitions for the transmit layer: state encodings, FIFO indices,
// FIFO geometry and default thresholds used by the flow controller, FIFOs and arbiter.
package tx_layer_pkg;

  localparam int NUM_FIFOS  = 4;
  localparam int DEPTH      = 8;
  localparam int CW         = 4;
  localparam int AF_DEFAULT = 6;
  localparam int AE_DEFAULT = 1;
  localparam int IDLE_HOLD  = 2;

  // Bit positions of each FIFO in the fifo_empty/fifo_full/error_out vectors
  localparam int IDX_VC0 = 0;
  localparam int IDX_VC1 = 1;
  localparam int IDX_D0  = 2;
  localparam int IDX_D1  = 3;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } tx_state_e;

endpackage

// File: rtl/tx_idle_hold_cnt.sv
// Saturating counter of consecutive all-empty cycles; done fires on the
// increment that reaches IDLE_HOLD so the caller can leave ACTIVE on that edge.
module tx_idle_hold_cnt #(
  parameter int IDLE_HOLD = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic done
);

  localparam int W = $clog2(IDLE_HOLD + 1);

  logic [W-1:0] cnt;

  assign done = inc && (cnt >= W'(IDLE_HOLD - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (inc && (cnt != W'(IDLE_HOLD))) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tx_flow_ctrl.sv
// Link-level sequencing controller for the transmit VC arbiter and its FIFOs:
// RESET/INIT/IDLE/ACTIVE/ERROR state machine, threshold latching and status.
module tx_flow_ctrl
  import tx_layer_pkg::*;
#(
  parameter int NUM_FIFOS  = tx_layer_pkg::NUM_FIFOS,
  parameter int DEPTH      = tx_layer_pkg::DEPTH,
  parameter int CW         = tx_layer_pkg::CW,
  parameter int AF_DEFAULT = tx_layer_pkg::AF_DEFAULT,
  parameter int AE_DEFAULT = tx_layer_pkg::AE_DEFAULT,
  parameter int IDLE_HOLD  = tx_layer_pkg::IDLE_HOLD
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [CW-1:0]        thr_af_in,
  input  logic [CW-1:0]        thr_ae_in,
  input  logic [NUM_FIFOS-1:0] fifo_empty,
  input  logic [NUM_FIFOS-1:0] fifo_full,
  output logic [CW-1:0]        thr_af,
  output logic [CW-1:0]        thr_ae,
  output logic                 arb_enable,
  output logic                 idle,
  output logic                 active,
  output logic [NUM_FIFOS-1:0] error_out,
  output logic [2:0]           state
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_DEF  = CW'(AF_DEFAULT);
  localparam logic [CW-1:0] AE_DEF  = CW'(AE_DEFAULT);

  tx_state_e     state_q;
  logic [CW-1:0] cand_af;
  logic [CW-1:0] cand_ae;
  logic          any_full;
  logic          all_empty;
  logic          cand_valid;
  logic          hold_inc;
  logic          hold_clear;
  logic          hold_done;

  assign any_full   = |fifo_full;
  assign all_empty  = &fifo_empty;
  assign cand_valid = (cand_ae < cand_af) && (cand_af <= DEPTH_C);

  assign hold_inc   = (state_q == ST_ACTIVE) && all_empty && !any_full;
  assign hold_clear = !hold_inc || hold_done;

  tx_idle_hold_cnt #(
    .IDLE_HOLD(IDLE_HOLD)
  ) u_hold (
    .clk  (clk),
    .reset(reset),
    .clear(hold_clear),
    .inc  (hold_inc),
    .done (hold_done)
  );

  assign state      = state_q;
  assign arb_enable = (state_q == ST_ACTIVE);
  assign active     = (state_q == ST_ACTIVE);
  assign idle       = (state_q == ST_IDLE);

  // Candidate is also captured on the IDLE->INIT edge so a one-cycle init
  // request still carries its thresholds into validation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RESET;
      thr_af    <= AF_DEF;
      thr_ae    <= AE_DEF;
      cand_af   <= AF_DEF;
      cand_ae   <= AE_DEF;
      error_out <= '0;
    end else begin
      unique case (state_q)
        ST_RESET: state_q <= ST_INIT;
        ST_INIT: begin
          if (init) begin
            cand_af <= thr_af_in;
            cand_ae <= thr_ae_in;
          end else if (cand_valid) begin
            thr_af  <= cand_af;
            thr_ae  <= cand_ae;
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_ERROR;
          end
        end
        ST_IDLE: begin
          if (any_full) begin
            error_out <= fifo_full;
            state_q   <= ST_ERROR;
          end else if (init) begin
            cand_af <= thr_af_in;
            cand_ae <= thr_ae_in;
            state_q <= ST_INIT;
          end else if (!all_empty) begin
            state_q <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (any_full) begin
            error_out <= fifo_full;
            state_q   <= ST_ERROR;
          end else if (hold_done) begin
            state_q <= ST_IDLE;
          end
        end
        ST_ERROR: error_out <= error_out | fifo_full;
        default:  state_q <= ST_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_flow_ctrl.sv
// Self-checking bench for tx_flow_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a behavioural model.
module tb_tx_flow_ctrl;

  localparam int NF = 4;
  localparam int CWB = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           init;
  logic [CWB-1:0] thr_af_in;
  logic [CWB-1:0] thr_ae_in;
  logic [NF-1:0]  fifo_empty;
  logic [NF-1:0]  fifo_full;
  logic [CWB-1:0] thr_af;
  logic [CWB-1:0] thr_ae;
  logic           arb_enable;
  logic           idle;
  logic           active;
  logic [NF-1:0]  error_out;
  logic [2:0]     state;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // Behavioural model: state numbers follow the link-level encoding
  int m_state = 0;
  int m_af    = 6;
  int m_ae    = 1;
  int m_cand_af = 6;
  int m_cand_ae = 1;
  int m_err   = 0;
  int m_run   = 0;

  tx_flow_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .init      (init),
    .thr_af_in (thr_af_in),
    .thr_ae_in (thr_ae_in),
    .fifo_empty(fifo_empty),
    .fifo_full (fifo_full),
    .thr_af    (thr_af),
    .thr_ae    (thr_ae),
    .arb_enable(arb_enable),
    .idle      (idle),
    .active    (active),
    .error_out (error_out),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Inputs are stable at the rising edge because they only change at falling edges
  always @(posedge clk) begin : model
    int s, af, ae, ca, cb, err, run;
    s = m_state; af = m_af; ae = m_ae; ca = m_cand_af; cb = m_cand_ae;
    err = m_err; run = m_run;
    if (reset) begin
      s = 0; af = 6; ae = 1; ca = 6; cb = 1; err = 0; run = 0;
    end else if (s == 0) begin
      s = 1;
    end else if (s == 1) begin
      if (init) begin
        ca = int'(thr_af_in); cb = int'(thr_ae_in);
      end else if (cb < ca && ca <= 8) begin
        af = ca; ae = cb; s = 2;
      end else begin
        s = 4;
      end
    end else if (s == 2) begin
      if (fifo_full != 0) begin
        err = int'(fifo_full); s = 4;
      end else if (init) begin
        ca = int'(thr_af_in); cb = int'(thr_ae_in); s = 1;
      end else if (fifo_empty != 4'hF) begin
        s = 3; run = 0;
      end
    end else if (s == 3) begin
      if (fifo_full != 0) begin
        err = int'(fifo_full); s = 4; run = 0;
      end else if (fifo_empty == 4'hF) begin
        run = run + 1;
        if (run >= 2) begin
          s = 2; run = 0;
        end
      end else begin
        run = 0;
      end
    end else begin
      err = err | int'(fifo_full);
    end
    m_state <= s; m_af <= af; m_ae <= ae; m_cand_af <= ca; m_cand_ae <= cb;
    m_err <= err; m_run <= run;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("state",      int'(state),      m_state);
      checkOutput("thr_af",     int'(thr_af),     m_af);
      checkOutput("thr_ae",     int'(thr_ae),     m_ae);
      checkOutput("arb_enable", int'(arb_enable), int'(m_state == 3));
      checkOutput("idle",       int'(idle),       int'(m_state == 2));
      checkOutput("active",     int'(active),     int'(m_state == 3));
      checkOutput("error_out",  int'(error_out),  m_err);
    end
  end

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input bit rst, input bit in_init, input int af, input int ae,
                               input logic [NF-1:0] emp, input logic [NF-1:0] ful);
    reset = rst; init = in_init;
    thr_af_in = CWB'(af); thr_ae_in = CWB'(ae);
    fifo_empty = emp; fifo_full = ful;
    cycle();
  endtask

  task automatic restart();
    applyStimulus(1, 0, 0, 0, 4'hF, 4'h0);
    applyStimulus(0, 0, 0, 0, 4'hF, 4'h0);
    applyStimulus(0, 0, 0, 0, 4'hF, 4'h0);
  endtask

  initial begin
    int init_left;
    reset = 1'b1; init = 1'b0; thr_af_in = '0; thr_ae_in = '0;
    fifo_empty = 4'hF; fifo_full = 4'h0;
    @(negedge clk);
    applyStimulus(1, 0, 0, 0, 4'hF, 4'h0);
    applyStimulus(1, 0, 0, 0, 4'hF, 4'h0);
    chk_en = 1'b1;
    checkOutput("lit rst state", int'(state), 0);
    checkOutput("lit rst thr_af", int'(thr_af), 6);
    checkOutput("lit rst thr_ae", int'(thr_ae), 1);
    checkOutput("lit rst arb", int'(arb_enable), 0);

    applyStimulus(0, 0, 0, 0, 4'hF, 4'h0);
    checkOutput("lit init state", int'(state), 1);
    applyStimulus(0, 0, 0, 0, 4'hF, 4'h0);
    checkOutput("lit idle state", int'(state), 2);

    // Reconfigure with a one-cycle init request
    applyStimulus(0, 1, 5, 2, 4'hF, 4'h0);
    checkOutput("lit cfg init", int'(state), 1);
    applyStimulus(0, 0, 0, 0, 4'hF, 4'h0);
    checkOutput("lit cfg state", int'(state), 2);
    checkOutput("lit cfg af", int'(thr_af), 5);
    checkOutput("lit cfg ae", int'(thr_ae), 2);

    // Traffic, ignored init while active, then two empty cycles back to IDLE
    applyStimulus(0, 0, 0, 0, 4'b1110, 4'h0);
    checkOutput("lit act state", int'(state), 3);
    checkOutput("lit act arb", int'(arb_enable), 1);
    applyStimulus(0, 1, 7, 0, 4'b1110, 4'h0);
    applyStimulus(0, 0, 0, 0, 4'b1110, 4'h0);
    applyStimulus(0, 0, 0, 0, 4'hF, 4'h0);
    checkOutput("lit hold1", int'(state), 3);
    applyStimulus(0, 0, 0, 0, 4'hF, 4'h0);
    checkOutput("lit hold2", int'(state), 2);
    checkOutput("lit hold af", int'(thr_af), 5);

    // Boundary: af == DEPTH is accepted
    applyStimulus(0, 1, 8, 7, 4'hF, 4'h0);
    applyStimulus(0, 0, 0, 0, 4'hF, 4'h0);
    checkOutput("lit af8 state", int'(state), 2);
    checkOutput("lit af8 af", int'(thr_af), 8);

    // Invalid thresholds keep the old values and land in ERROR
    applyStimulus(0, 1, 2, 3, 4'hF, 4'h0);
    applyStimulus(0, 0, 0, 0, 4'hF, 4'h0);
    checkOutput("lit bad state", int'(state), 4);
    checkOutput("lit bad af", int'(thr_af), 8);
    checkOutput("lit bad err", int'(error_out), 0);
    applyStimulus(1, 0, 0, 0, 4'hF, 4'h0);
    checkOutput("lit err rst state", int'(state), 0);
    checkOutput("lit err rst af", int'(thr_af), 6);
    applyStimulus(0, 0, 0, 0, 4'hF, 4'h0);
    checkOutput("lit err rel state", int'(state), 1);
    applyStimulus(0, 0, 0, 0, 4'hF, 4'h0);

    // af above DEPTH and af of zero are both rejected
    applyStimulus(0, 1, 9, 1, 4'hF, 4'h0);
    applyStimulus(0, 0, 0, 0, 4'hF, 4'h0);
    checkOutput("lit af9 state", int'(state), 4);
    restart();
    applyStimulus(0, 1, 0, 0, 4'hF, 4'h0);
    applyStimulus(0, 0, 0, 0, 4'hF, 4'h0);
    checkOutput("lit af0 state", int'(state), 4);
    restart();

    // Full while active, accumulating error mask
    applyStimulus(0, 0, 0, 0, 4'b0111, 4'h0);
    applyStimulus(0, 0, 0, 0, 4'b0111, 4'b0100);
    checkOutput("lit full state", int'(state), 4);
    checkOutput("lit full err", int'(error_out), 4);
    applyStimulus(0, 0, 0, 0, 4'b0111, 4'b0001);
    checkOutput("lit full err2", int'(error_out), 5);
    applyStimulus(0, 0, 0, 0, 4'hF, 4'h0);
    checkOutput("lit full stay", int'(state), 4);
    restart();

    // Full and empty together on one FIFO counts as full
    applyStimulus(0, 0, 0, 0, 4'hF, 4'b0001);
    checkOutput("lit fe state", int'(state), 4);
    checkOutput("lit fe err", int'(error_out), 1);
    restart();

    // Reset in the middle of traffic
    applyStimulus(0, 0, 0, 0, 4'b1110, 4'h0);
    applyStimulus(1, 0, 0, 0, 4'b1110, 4'h0);
    checkOutput("lit mid rst state", int'(state), 0);
    checkOutput("lit mid rst arb", int'(arb_enable), 0);
    applyStimulus(0, 0, 0, 0, 4'hF, 4'h0);
    checkOutput("lit mid rel state", int'(state), 1);

    // Randomized traffic; init requests last at least two cycles with stable thresholds
    init_left = 0;
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 79) == 0);
      if (init_left > 0) begin
        init = 1'b1;
        init_left--;
      end else if ($urandom_range(0, 24) == 0) begin
        init = 1'b1;
        init_left = $urandom_range(1, 3);
        thr_af_in = CWB'($urandom_range(0, 9));
        thr_ae_in = CWB'($urandom_range(0, 7));
      end else begin
        init = 1'b0;
      end
      fifo_empty = ($urandom_range(0, 1) == 0) ? 4'hF : NF'($urandom);
      fifo_full  = ($urandom_range(0, 59) == 0) ? NF'($urandom_range(1, 15)) : 4'h0;
      cycle();
    end

    chk_en = 1'b0;
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
